// File: rtl/instr_loader_if.sv
// Byte-stream, instruction-memory and status signals of the instruction loader.
// master: the side that supplies the image and observes the loader.
// slave:  the loader itself.
interface instr_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        cpu_n_rst;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, byte_valid, byte_data, byte_last,
        input  byte_ready, imem_we, imem_addr, imem_data,
        input  cpu_n_rst, busy, done, error
    );

    modport slave (
        input  start, byte_valid, byte_data, byte_last,
        output byte_ready, imem_we, imem_addr, imem_data,
        output cpu_n_rst, busy, done, error
    );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory at consecutive word addresses and keeps
// the pipeline core in reset until a complete image has been loaded.
// Optional feature macro: LOADER_CHECKSUM_EN -- after the byte_last word one
// extra checksum word is consumed (not written) and compared against the
// 32-bit wrap-around sum of all written words.
module instr_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          n_rst,
    instr_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MAX_WORDS - 1);

    state_t      state;
    state_t      nxt;
    logic [31:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;     // bytes 0..2 of the word being assembled
    logic        last_q;    // word sitting in WRITE carried byte_last
    logic [31:0] word;
    logic        xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;     // running sum of written words
    logic        chk_q;     // image done, now collecting the checksum word
`endif

    // Byte 3 completes the word straight from the input bus.
    always_comb begin
        word = {asm_q, bus.byte_data};
        xfer = bus.byte_valid && bus.byte_ready;
    end

    // Next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.start) nxt = LOAD;
            end
            LOAD: begin
                if (xfer) begin
                    if (byte_cnt == 2'd3) begin
                        nxt = WRITE;
`ifdef LOADER_CHECKSUM_EN
                        if (chk_q) nxt = (word == sum_q) ? DONE : ERR;
`endif
                    end else if (bus.byte_last) begin
                        // image ended mid-word: drop the partial word
                        nxt = ERR;
                    end
                end
            end
            WRITE: begin
                if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
                    nxt = LOAD;
`else
                    nxt = DONE;
`endif
                end else if (word_cnt == LAST_WORD) begin
                    nxt = ERR;
                end else begin
                    nxt = LOAD;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State, counters, assembly datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state          <= IDLE;
            word_cnt       <= '0;
            byte_cnt       <= '0;
            asm_q          <= '0;
            last_q         <= 1'b0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_data  <= '0;
            bus.cpu_n_rst  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= '0;
            chk_q          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        asm_q    <= '0;
                        last_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q    <= '0;
                        chk_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    asm_q[23:16] <= bus.byte_data;
                            2'd1:    asm_q[15:8]  <= bus.byte_data;
                            2'd2:    asm_q[7:0]   <= bus.byte_data;
                            default: ;
                        endcase
                        if (nxt == WRITE) begin
                            bus.imem_data <= word;
                            bus.imem_addr <= {word_cnt[29:0], 2'b00};
                            last_q        <= bus.byte_last;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_q    <= sum_q + bus.imem_data;
                    if (last_q) chk_q <= 1'b1;
`endif
                end
                default: ;
            endcase

            state          <= nxt;
            bus.byte_ready <= (nxt == LOAD);
            bus.imem_we    <= (nxt == WRITE);
            bus.busy       <= (nxt == LOAD) || (nxt == WRITE);
            bus.done       <= (nxt == DONE);
            bus.error      <= (nxt == ERR);
            bus.cpu_n_rst  <= (nxt == DONE);
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a table of single-word images plus
// hand-written sequences for gapped streams, misalignment, the image limit,
// mid-load reset and (when LOADER_CHECKSUM_EN is defined) the checksum word.
module tb_instr_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       start, bv, bl;
    logic [7:0] bd;
    logic       sel;   // 0: MAX_WORDS=256 instance, 1: MAX_WORDS=4 instance

    instr_loader_if bus_a();
    instr_loader_if bus_b();

    assign bus_a.start      = start;
    assign bus_a.byte_valid = bv;
    assign bus_a.byte_data  = bd;
    assign bus_a.byte_last  = bl;
    assign bus_b.start      = start;
    assign bus_b.byte_valid = bv;
    assign bus_b.byte_data  = bd;
    assign bus_b.byte_last  = bl;

    instr_loader #(.MAX_WORDS(256)) dut  (.clk(clk), .n_rst(n_rst), .bus(bus_a));
    instr_loader #(.MAX_WORDS(4))   dut4 (.clk(clk), .n_rst(n_rst), .bus(bus_b));

    logic        o_ready, o_we, o_cpu, o_busy, o_done, o_err;
    logic [31:0] o_addr, o_data;

    always_comb begin
        if (sel) begin
            o_ready = bus_b.byte_ready; o_we   = bus_b.imem_we;
            o_addr  = bus_b.imem_addr;  o_data = bus_b.imem_data;
            o_cpu   = bus_b.cpu_n_rst;  o_busy = bus_b.busy;
            o_done  = bus_b.done;       o_err  = bus_b.error;
        end else begin
            o_ready = bus_a.byte_ready; o_we   = bus_a.imem_we;
            o_addr  = bus_a.imem_addr;  o_data = bus_a.imem_data;
            o_cpu   = bus_a.cpu_n_rst;  o_busy = bus_a.busy;
            o_done  = bus_a.done;       o_err  = bus_a.error;
        end
    end

    // Write log of the observed instance, sampled mid-cycle.
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          ready_in_write = 0;
    always @(negedge clk) begin
        if (o_we) begin
            wa.push_back(o_addr);
            wd.push_back(o_data);
            if (o_ready) ready_in_write++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; start = 1'b0; bv = 1'b0; bl = 1'b0; bd = 8'h00;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        bv = 1'b1; bd = b; bl = last;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_byte_timeout", 32'(n), 32'd0);
        tick();
        bv = 1'b0; bl = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input logic gap);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[31:24], last && (k == 3));
            t = t << 8;
            if (gap) tick();
        end
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(o_done || o_err) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check({name, "_timeout"}, 32'(n), 32'd0);
    endtask

    typedef struct packed {
        logic [7:0]  b0, b1, b2, b3;
        logic        gap;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t vt[4];
        int   base;
        int   rdy0;
        int   n;

        vt[0] = '{8'h20, 8'h01, 8'h00, 8'h05, 1'b0, 32'h20010005};
        vt[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1, 32'hDEADBEEF};
        vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 32'h00000000};
        vt[3] = '{8'hFF, 8'h00, 8'hFF, 8'h01, 1'b1, 32'hFF00FF01};

        sel = 1'b0;
        do_reset();
        check("reset_flags", {26'd0, o_ready, o_we, o_cpu, o_busy, o_done, o_err}, 32'd0);
        check("reset_addr", o_addr, 32'd0);
        check("reset_data", o_data, 32'd0);

`ifndef LOADER_CHECKSUM_EN
        // Single-word images; the first starts from IDLE, the rest reload from DONE.
        for (int i = 0; i < 4; i++) begin
            base = wa.size();
            pulse_start();
            check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'd1);
            check($sformatf("vec%0d_core_held", i), 32'(o_cpu), 32'd0);
            send_byte(vt[i].b0, 1'b0); if (vt[i].gap) tick();
            send_byte(vt[i].b1, 1'b0); if (vt[i].gap) tick();
            send_byte(vt[i].b2, 1'b0); if (vt[i].gap) tick();
            send_byte(vt[i].b3, 1'b1);
            wait_end($sformatf("vec%0d", i));
            check($sformatf("vec%0d_nwrites", i), 32'(wa.size() - base), 32'd1);
            if (wa.size() > base) begin
                check($sformatf("vec%0d_addr", i), wa[base], 32'h0);
                check($sformatf("vec%0d_data", i), wd[base], vt[i].exp);
            end
            check($sformatf("vec%0d_done", i), 32'(o_done), 32'd1);
            check($sformatf("vec%0d_cpu_n_rst", i), 32'(o_cpu), 32'd1);
            check($sformatf("vec%0d_error", i), 32'(o_err), 32'd0);
            check($sformatf("vec%0d_idle_busy", i), 32'(o_busy), 32'd0);
        end

        // Three words with byte_valid gapped every other cycle.
        base = wa.size();
        rdy0 = ready_in_write;
        pulse_start();
        send_word(32'h11223344, 1'b0, 1'b1);
        send_word(32'h55667788, 1'b0, 1'b1);
        send_word(32'h99AABBCC, 1'b1, 1'b1);
        wait_end("gap3");
        check("gap3_nwrites", 32'(wa.size() - base), 32'd3);
        if (wa.size() >= base + 3) begin
            check("gap3_addr0", wa[base],   32'h0);
            check("gap3_addr1", wa[base+1], 32'h4);
            check("gap3_addr2", wa[base+2], 32'h8);
            check("gap3_data0", wd[base],   32'h11223344);
            check("gap3_data1", wd[base+1], 32'h55667788);
            check("gap3_data2", wd[base+2], 32'h99AABBCC);
        end
        check("gap3_ready_in_write", 32'(ready_in_write - rdy0), 32'd0);
        check("gap3_done", 32'(o_done), 32'd1);

        // byte_last on the second byte of a word.
        base = wa.size();
        pulse_start();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        wait_end("misalign");
        check("misalign_error", 32'(o_err), 32'd1);
        check("misalign_done", 32'(o_done), 32'd0);
        check("misalign_cpu_n_rst", 32'(o_cpu), 32'd0);
        check("misalign_nwrites", 32'(wa.size() - base), 32'd0);
        tick();
        check("misalign_sticky", 32'(o_err), 32'd1);
        pulse_start();
        check("restart_busy", 32'(o_busy), 32'd1);
        check("restart_error", 32'(o_err), 32'd0);
        check("restart_ready", 32'(o_ready), 32'd1);

        // Image limit on the MAX_WORDS=4 instance: five words overflow.
        sel = 1'b1;
        do_reset();
        base = wa.size();
        pulse_start();
        send_word(32'h01000000, 1'b0, 1'b0);
        send_word(32'h01000001, 1'b0, 1'b0);
        send_word(32'h01000002, 1'b0, 1'b0);
        send_word(32'h01000003, 1'b0, 1'b0);
        bv = 1'b1; bd = 8'h55; bl = 1'b0;
        n = 0;
        while (!o_err && n < 40) begin
            tick();
            n++;
        end
        check("limit_wait", 32'(n < 40), 32'd1);
        bv = 1'b0;
        check("limit_error", 32'(o_err), 32'd1);
        check("limit_nwrites", 32'(wa.size() - base), 32'd4);
        if (wa.size() >= base + 4) begin
            check("limit_last_addr", wa[base+3], 32'hC);
            check("limit_last_data", wd[base+3], 32'h01000003);
        end
        check("limit_cpu_n_rst", 32'(o_cpu), 32'd0);

        // Exactly MAX_WORDS words fits.
        base = wa.size();
        pulse_start();
        send_word(32'hA0000000, 1'b0, 1'b0);
        send_word(32'hA0000001, 1'b0, 1'b0);
        send_word(32'hA0000002, 1'b0, 1'b0);
        send_word(32'hA0000003, 1'b1, 1'b0);
        wait_end("fit");
        check("fit_done", 32'(o_done), 32'd1);
        check("fit_nwrites", 32'(wa.size() - base), 32'd4);
        if (wa.size() >= base + 4) check("fit_last_addr", wa[base+3], 32'hC);

        // Reset after six bytes, then reload.
        sel = 1'b0;
        do_reset();
        base = wa.size();
        pulse_start();
        send_word(32'hA1A2A3A4, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA6, 1'b0);
        n_rst = 1'b0;
        tick();
        check("midrst_flags", {26'd0, o_ready, o_we, o_cpu, o_busy, o_done, o_err}, 32'd0);
        check("midrst_addr", o_addr, 32'd0);
        check("midrst_data", o_data, 32'd0);
        n_rst = 1'b1;
        repeat (3) tick();
        check("midrst_nwrites", 32'(wa.size() - base), 32'd1);
        base = wa.size();
        pulse_start();
        send_word(32'hB0B1B2B3, 1'b1, 1'b0);
        wait_end("reload");
        check("reload_nwrites", 32'(wa.size() - base), 32'd1);
        if (wa.size() > base) begin
            check("reload_addr", wa[base], 32'h0);
            check("reload_data", wd[base], 32'hB0B1B2B3);
        end
        check("reload_done", 32'(o_done), 32'd1);
`else
        // Checksum build: words 1,2 followed by checksum 3 (good) then 4 (bad).
        base = wa.size();
        pulse_start();
        send_word(32'h00000001, 1'b0, 1'b0);
        send_word(32'h00000002, 1'b1, 1'b0);
        send_word(32'h00000003, 1'b0, 1'b0);
        wait_end("chk_good");
        check("chk_good_done", 32'(o_done), 32'd1);
        check("chk_good_error", 32'(o_err), 32'd0);
        check("chk_good_nwrites", 32'(wa.size() - base), 32'd2);
        if (wa.size() >= base + 2) begin
            check("chk_good_addr1", wa[base+1], 32'h4);
            check("chk_good_data1", wd[base+1], 32'h2);
        end
        base = wa.size();
        pulse_start();
        send_word(32'h00000001, 1'b0, 1'b0);
        send_word(32'h00000002, 1'b1, 1'b0);
        send_word(32'h00000004, 1'b0, 1'b0);
        wait_end("chk_bad");
        check("chk_bad_error", 32'(o_err), 32'd1);
        check("chk_bad_done", 32'(o_done), 32'd0);
        check("chk_bad_cpu_n_rst", 32'(o_cpu), 32'd0);
        check("chk_bad_nwrites", 32'(wa.size() - base), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: MAX_WORDS, 256, instruction memory depth in 32-bit words; image limit.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: n_rst  input  1  reset; synchronous and active-low.
REQ-004 Port: start  input  1  one-cycle request to begin a load.
REQ-005 Port: byte_valid  input  1  byte_data holds a valid image byte.
REQ-006 Port: byte_data  input  8  image byte; big-endian within each word.
REQ-007 Port: byte_last  input  1  qualifies the final byte of the image (with byte_valid).
REQ-008 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port: imem_we  output  1  instruction memory write strobe.
REQ-010 Port: imem_addr  output  32  byte address, word-aligned ([1:0]=0), matching program counter addressing.
REQ-011 Port: imem_data  output  32  assembled instruction word.
REQ-012 Port: cpu_n_rst  output  1  active-low reset driven to the pipeline core.
REQ-013 Port: busy  output  1  load in progress.
REQ-014 Port: done  output  1  image loaded successfully.
REQ-015 Port: error  output  1  load aborted; sticky until start or reset.

Function
REQ-016 States SHALL be IDLE, LOAD, WRITE, DONE, ERR.
REQ-017 IDLE->LOAD on start; LOAD or WRITE ignores start; DONE or ERR->LOAD on start, clearing word counter, byte counter and error.
REQ-018 A byte SHALL transfer only on byte_valid && byte_ready; byte_ready SHALL be 1 only in LOAD.
REQ-019 Byte k of a word (k=0..3) SHALL be placed in bits [31-8k:24-8k]; 2-bit byte counter wraps 3->0.
REQ-020 Transfer of byte 3 at edge N SHALL put the FSM in WRITE during cycle N+1, with imem_we=1, imem_data=assembled word, imem_addr=word_cnt<<2.
REQ-021 imem_we SHALL be high for exactly one cycle per word and 0 in all other states.
REQ-022 word_cnt SHALL increment at the end of WRITE; WRITE->LOAD unless the word carried byte_last (->DONE) or word_cnt was MAX_WORDS-1 (->ERR).
REQ-023 byte_last on byte 0..2 (misaligned image) SHALL go to ERR with no write of the partial word.
REQ-024 busy=1 in LOAD and WRITE; done=1 only in DONE; error=1 only in ERR.
REQ-025 cpu_n_rst SHALL be 1 only in DONE; the core is held in reset in every other state, including a reload.
REQ-026 byte_valid with byte_ready=0 SHALL be ignored; no byte is lost or duplicated across a stalled handshake.

Reset
REQ-027 On clk edge with n_rst=0: state=IDLE, word_cnt=0, byte counter=0, assembly register=0.
REQ-028 Reset outputs: byte_ready=0, imem_we=0, imem_addr=0, imem_data=0, cpu_n_rst=0, busy=0, done=0, error=0.
REQ-029 Reset mid-load SHALL abort with no further imem_we; memory contents already written are left as is.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN: when defined, the loader SHALL accumulate a 32-bit wrap-around sum of all written words. The word after the byte_last word is a checksum word, consumed but not written. Sum equal -> DONE, else -> ERR. Image words remain limited to MAX_WORDS.
REQ-031 Without LOADER_CHECKSUM_EN: no checksum phase; the byte_last word ends the load; no sum logic is present.

Verification
REQ-032 Reset, start, bytes 0x20,0x01,0x00,0x05 with last on byte 4 -> one imem_we, addr 0x0, data 0x20010005, then done=1, cpu_n_rst=1.
REQ-033 3-word image with byte_valid gapped every other cycle -> writes at addr 0x0,0x4,0x8 in order, data intact, byte_ready low during each WRITE.
REQ-034 byte_last on 2nd byte -> error=1, no imem_we, cpu_n_rst=0; a following start -> busy=1, error=0.
REQ-035 MAX_WORDS=4, 5-word image -> 4 writes (last addr 0xC), then error=1 before the 5th word is written.
REQ-036 n_rst low after 6 bytes -> next cycle all outputs at reset values, no second write; a new start reloads from addr 0x0.
REQ-037 LOADER_CHECKSUM_EN defined, words 0x1,0x2 + checksum 0x3 -> done=1; checksum 0x4 -> error=1; checksum word never written.
